// File: rtl/fg_prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// fg_prog_sequencer_if
// Program-command channel into the floating-gate programming sequencer.
// The producer offers one command (row, column, pulse count, pulse width,
// inject/tunnel) with cmd_valid; the sequencer takes it on the cycle where
// cmd_valid && cmd_ready.
//
// Signals:
//   cmd_valid   producer -> sequencer   command offered
//   cmd_ready   sequencer -> producer   sequencer idle, can accept
//   cmd_row     producer -> sequencer   target row (vertical decode)
//   cmd_col     producer -> sequencer   target column (horizontal decode)
//   cmd_npulse  producer -> sequencer   number of pulses
//   cmd_width   producer -> sequencer   pulse width in clock cycles
//   cmd_tunnel  producer -> sequencer   1 = tunnel (erase), 0 = inject
//
// Modports: master (command producer), slave (sequencer).
// ---------------------------------------------------------------------------
interface fg_prog_sequencer_if #(
  parameter int COL_BITS = 4,
  parameter int ROW_BITS = 3,
  parameter int NP_BITS  = 8,
  parameter int PW_BITS  = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;
  logic [NP_BITS-1:0]  cmd_npulse;
  logic [PW_BITS-1:0]  cmd_width;
  logic                cmd_tunnel;

  modport master (
    output cmd_valid, cmd_row, cmd_col, cmd_npulse, cmd_width, cmd_tunnel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_row, cmd_col, cmd_npulse, cmd_width, cmd_tunnel,
    output cmd_ready
  );
endinterface

// File: rtl/fg_prog_sequencer.sv
// ---------------------------------------------------------------------------
// fg_prog_sequencer
// Programming controller for one floating-gate island. Accepts a program
// command and walks SETUP -> (PULSE -> GAP)* -> RELEASE -> DONE, driving the
// row/column VINJ decode tiles, the program/run switch select and the
// injection / tunnel pulse enables. Every output is a register.
//
// Optional feature (macro FG_PROG_VERIFY_EN): adds a VERIFY state after each
// GAP with a meas_req/meas_ack/meas_pass handshake to an external
// measurement block; a pass terminates the command early.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   cmd          command channel (fg_prog_sequencer_if.slave)
//   abort        terminate the current command (SETUP/PULSE/GAP[/VERIFY])
//   row_addr     vertical decoder address
//   col_addr     horizontal decoder address
//   dec_en       decoder enable
//   prog_mode    program/run switch select (1 = program)
//   inj_pulse    injection pulse
//   tun_en       tunnel pulse
//   busy         sequencer not idle
//   done         one-cycle completion strobe
//   aborted      sticky: last command was aborted
//   pulse_cnt    pulses issued for the current/last command
//   meas_req/meas_ack/meas_pass   verify handshake (FG_PROG_VERIFY_EN only)
// ---------------------------------------------------------------------------
module fg_prog_sequencer #(
  parameter int COL_BITS = 4,
  parameter int ROW_BITS = 3,
  parameter int NP_BITS  = 8,
  parameter int PW_BITS  = 16,
  parameter int SETTLE   = 4
) (
  input  logic                clk,
  input  logic                rst,
  fg_prog_sequencer_if.slave  cmd,
  input  logic                abort,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [COL_BITS-1:0] col_addr,
  output logic                dec_en,
  output logic                prog_mode,
  output logic                inj_pulse,
  output logic                tun_en,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [NP_BITS-1:0]  pulse_cnt
`ifdef FG_PROG_VERIFY_EN
  ,
  output logic                meas_req,
  input  logic                meas_ack,
  input  logic                meas_pass
`endif
);

  // The timer holds either a settle count or a pulse width, so it is sized
  // for whichever is wider.
  localparam int SET_BITS = $clog2(SETTLE + 1);
  localparam int TMR_BITS = (PW_BITS > SET_BITS) ? PW_BITS : SET_BITS;
  localparam logic [TMR_BITS-1:0] SETTLE_LOAD = TMR_BITS'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_GAP     = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
`ifdef FG_PROG_VERIFY_EN
    ,
    S_VERIFY  = 3'd6
`endif
  } state_t;

  state_t              state_q;
  logic                cmd_ready_q;
  logic [TMR_BITS-1:0] timer_q;
  logic [NP_BITS-1:0]  npulse_q;
  logic [PW_BITS-1:0]  width_q;
  logic                tunnel_q;

  // Timer counts down to zero; state duration D is loaded as D-1.
  // A zero width still yields a one-cycle pulse.
  logic                timer_done_d;
  logic [TMR_BITS-1:0] width_load_d;
  logic                pulses_left_d;
  logic [NP_BITS-1:0]  pulse_cnt_inc_d;

  assign timer_done_d    = (timer_q == '0);
  assign width_load_d    = (width_q == '0) ? '0 : TMR_BITS'(width_q - PW_BITS'(1));
  assign pulses_left_d   = (pulse_cnt < npulse_q);
  // Saturate at the requested count so the counter can never pass npulse.
  assign pulse_cnt_inc_d = pulses_left_d ? (pulse_cnt + NP_BITS'(1)) : pulse_cnt;

  assign cmd.cmd_ready = cmd_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      timer_q     <= '0;
      npulse_q    <= '0;
      width_q     <= '0;
      tunnel_q    <= 1'b0;
      row_addr    <= '0;
      col_addr    <= '0;
      dec_en      <= 1'b0;
      prog_mode   <= 1'b0;
      inj_pulse   <= 1'b0;
      tun_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      pulse_cnt   <= '0;
`ifdef FG_PROG_VERIFY_EN
      meas_req    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // cmd_ready is registered high throughout IDLE.
          if (cmd.cmd_valid) begin
            npulse_q    <= cmd.cmd_npulse;
            width_q     <= cmd.cmd_width;
            tunnel_q    <= cmd.cmd_tunnel;
            row_addr    <= cmd.cmd_row;
            col_addr    <= cmd.cmd_col;
            prog_mode   <= 1'b1;
            busy        <= 1'b1;
            cmd_ready_q <= 1'b0;
            pulse_cnt   <= '0;
            aborted     <= 1'b0;
            timer_q     <= SETTLE_LOAD;
            state_q     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (abort) begin
            aborted <= 1'b1;
            timer_q <= SETTLE_LOAD;
            state_q <= S_RELEASE;
          end else if (timer_done_d) begin
            if (npulse_q == '0) begin
              timer_q <= SETTLE_LOAD;
              state_q <= S_RELEASE;
            end else begin
              dec_en    <= 1'b1;
              inj_pulse <= ~tunnel_q;
              tun_en    <= tunnel_q;
              timer_q   <= width_load_d;
              state_q   <= S_PULSE;
            end
          end else begin
            timer_q <= timer_q - TMR_BITS'(1);
          end
        end

        S_PULSE: begin
          if (abort) begin
            // Truncated pulse is dropped and not counted.
            dec_en    <= 1'b0;
            inj_pulse <= 1'b0;
            tun_en    <= 1'b0;
            aborted   <= 1'b1;
            timer_q   <= SETTLE_LOAD;
            state_q   <= S_RELEASE;
          end else if (timer_done_d) begin
            inj_pulse <= 1'b0;
            tun_en    <= 1'b0;
            pulse_cnt <= pulse_cnt_inc_d;
            timer_q   <= SETTLE_LOAD;
            state_q   <= S_GAP;
          end else begin
            timer_q <= timer_q - TMR_BITS'(1);
          end
        end

        S_GAP: begin
          if (abort) begin
            dec_en  <= 1'b0;
            aborted <= 1'b1;
            timer_q <= SETTLE_LOAD;
            state_q <= S_RELEASE;
          end else if (timer_done_d) begin
`ifdef FG_PROG_VERIFY_EN
            // Decoder is released while the cell is measured.
            dec_en   <= 1'b0;
            meas_req <= 1'b1;
            state_q  <= S_VERIFY;
`else
            if (pulses_left_d) begin
              inj_pulse <= ~tunnel_q;
              tun_en    <= tunnel_q;
              timer_q   <= width_load_d;
              state_q   <= S_PULSE;
            end else begin
              dec_en  <= 1'b0;
              timer_q <= SETTLE_LOAD;
              state_q <= S_RELEASE;
            end
`endif
          end else begin
            timer_q <= timer_q - TMR_BITS'(1);
          end
        end

`ifdef FG_PROG_VERIFY_EN
        S_VERIFY: begin
          if (abort) begin
            meas_req <= 1'b0;
            aborted  <= 1'b1;
            timer_q  <= SETTLE_LOAD;
            state_q  <= S_RELEASE;
          end else if (meas_ack) begin
            meas_req <= 1'b0;
            // A passing measurement ends the command early without
            // flagging an abort.
            if (!meas_pass && pulses_left_d) begin
              dec_en    <= 1'b1;
              inj_pulse <= ~tunnel_q;
              tun_en    <= tunnel_q;
              timer_q   <= width_load_d;
              state_q   <= S_PULSE;
            end else begin
              timer_q <= SETTLE_LOAD;
              state_q <= S_RELEASE;
            end
          end
        end
`endif

        S_RELEASE: begin
          if (timer_done_d) begin
            done      <= 1'b1;
            prog_mode <= 1'b0;
            row_addr  <= '0;
            col_addr  <= '0;
            state_q   <= S_DONE;
          end else begin
            timer_q <= timer_q - TMR_BITS'(1);
          end
        end

        S_DONE: begin
          busy        <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          // Unreachable encodings recover to a quiet idle.
          dec_en      <= 1'b0;
          prog_mode   <= 1'b0;
          inj_pulse   <= 1'b0;
          tun_en      <= 1'b0;
          busy        <= 1'b0;
          cmd_ready_q <= 1'b1;
          row_addr    <= '0;
          col_addr    <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fg_prog_sequencer.md
Name: fg_prog_sequencer

Overview:
- Digital programming controller for one floating-gate island.
- Takes program commands (row, column, pulse count, pulse width, inject/tunnel) over a valid/ready interface.
- Drives the row decoder (vertical VINJ decode tile), the column decoder (horizontal VINJ decode tile), the program/run switch select and the injection/tunnel pulse enables.
- It is the driving end of the decode/switch tiles that surround the FG array.

Parameters:
- COL_BITS, 4, width of horizontal (column) decode address.
- ROW_BITS, 3, width of vertical (row/drain) decode address.
- NP_BITS, 8, width of pulse-count field.
- PW_BITS, 16, width of pulse-width field (clock cycles).
- SETTLE, 4, settle cycles for SETUP, GAP and RELEASE (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept command
- cmd_row  in  ROW_BITS  target row
- cmd_col  in  COL_BITS  target column
- cmd_npulse  in  NP_BITS  number of pulses
- cmd_width  in  PW_BITS  pulse width in cycles
- cmd_tunnel  in  1  1=tunnel (erase), 0=inject
- abort  in  1  terminate current command
- row_addr  out  ROW_BITS  vertical decoder address
- col_addr  out  COL_BITS  horizontal decoder address
- dec_en  out  1  decoder enable
- prog_mode  out  1  switches to program mode (0=run)
- inj_pulse  out  1  injection pulse
- tun_en  out  1  tunnel pulse
- busy  out  1  not IDLE
- done  out  1  one-cycle completion strobe
- aborted  out  1  sticky: last command was aborted
- pulse_cnt  out  NP_BITS  pulses issued for current/last command

Behaviour:
- clk and rst: single clock domain; rst is synchronous, active-high.
- Reset values: cmd_ready=1; all other outputs 0; state IDLE.
- Handshake:
  - Accept on the cycle where cmd_valid&&cmd_ready (cycle T).
  - cmd_ready=1 only in IDLE. The command is latched at T.
  - At T: pulse_cnt and aborted are cleared.
- States: IDLE, SETUP, PULSE, GAP, RELEASE, DONE. All outputs are registered.
- SETUP, from T+1, SETTLE cycles:
  - row_addr/col_addr are driven from the latched command.
  - prog_mode=1, dec_en=0.
  - Then go to PULSE. If npulse==0, go to RELEASE instead.
- PULSE, max(width,1) cycles:
  - dec_en=1.
  - inj_pulse=1 if !tunnel, otherwise tun_en=1. Never both.
  - On exit, pulse_cnt increments.
- GAP, SETTLE cycles:
  - Pulse outputs are 0; dec_en=1.
  - Then go to PULSE if pulse_cnt<npulse, otherwise RELEASE.
- RELEASE, SETTLE cycles:
  - dec_en=0, pulse outputs 0, prog_mode=1, addresses held.
- DONE, 1 cycle:
  - done=1, prog_mode=0, addresses return to 0.
  - Next state IDLE, with cmd_ready=1 on the following cycle.
- busy=1 in every state except IDLE.
- Abort:
  - abort is sampled in SETUP, PULSE or GAP. On the next edge, pulse outputs are 0, state is RELEASE, and aborted=1.
  - A pulse truncated by abort is not counted.
  - abort is ignored in IDLE, RELEASE and DONE.
- Counters:
  - The width counter is PW_BITS and never wraps.
  - pulse_cnt saturates at npulse; npulse=2^NP_BITS-1 is legal.
- rst mid-command: all outputs return to their reset values on the next edge, including dropping any active pulse; the command is lost.
- cmd_valid while busy is held off (cmd_ready=0); no queueing.

Optional Feature:
- Macro: FG_PROG_VERIFY_EN.
- When defined:
  - Adds ports meas_req (out 1), meas_ack (in 1), meas_pass (in 1), and a VERIFY state after each GAP.
  - meas_req=1 from VERIFY entry until the cycle meas_ack=1, with dec_en=0.
  - On ack: meas_pass=1 goes to RELEASE (early termination, no abort flag). Otherwise go to PULSE if pulses remain, else RELEASE.
  - abort in VERIFY drops meas_req and goes to RELEASE.
- When undefined: the ports and the state are absent; GAP goes directly to PULSE or RELEASE.

Test Plan:
- Reset, then idle 5 cycles -> cmd_ready=1, all other outputs 0.
- Inject command row=5, col=9, npulse=3, width=10, SETTLE=4, accepted at T -> inj_pulse high 10 cycles ×3, first rising at T+5. done at T+5+3*(10+4)+4. pulse_cnt=3, tun_en never 1.
- Tunnel command npulse=1, width=0 -> tun_en high exactly 1 cycle, inj_pulse stays 0, done follows.
- npulse=0 -> SETUP→RELEASE→DONE, no pulses, pulse_cnt=0, done at T+9.
- abort during 2nd pulse of npulse=5 -> pulse drops the next edge, pulse_cnt=1, aborted=1, done after RELEASE; a new command is then accepted normally.
- rst asserted mid-PULSE -> inj_pulse, dec_en, prog_mode at 0 the next edge. With FG_PROG_VERIFY_EN: meas_pass=1 on the first verify -> pulse_cnt=1, done issued.
